vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator. Successor to the fixed 640x480 controller plus toggle divider.

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_sync_delay.sv | 30 +++
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing presets and width helpers for the VGA timing generator.
// 640x480@60 uses a 2:1 divider from 50 MHz; 800x600@72 runs at the full 50 MHz.
package vga_timing_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;

  localparam timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};
  localparam int      VGA_640X480_CLK_DIV = 2;

  localparam timing_t VGA_800X600_H = '{active: 800, fp: 56, sync: 120, bp: 64};
  localparam timing_t VGA_800X600_V = '{active: 600, fp: 37, sync: 6,   bp: 23};
  localparam int      VGA_800X600_CLK_DIV = 1;

  localparam int DEFAULT_PIPE = 1;

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int span_width(input int active, input int fp, input int sync, input int bp);
    return $clog2(span_total(active, fp, sync, bp));
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enabled shift register that aligns {hs, vs, de} with the pixel generator latency.
// DEPTH extra stages sit in front of the output register, so DEPTH=0 is a single register.
module vga_sync_delay #(
  parameter int         DEPTH = 1,
  parameter logic [2:0] INIT  = 3'b110
) (
  input  logic       clk_sys,
  input  logic       rst_b,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] d,
  output logic [2:0] q
);

  logic [2:0] stage [DEPTH+1];

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i <= DEPTH; i++) stage[i] <= INIT;
    end else if (clr) begin
      for (int i = 0; i <= DEPTH; i++) stage[i] <= INIT;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i <= DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-enable divider, X/Y counters,
// sync/blank decode and frame counter, with sync/blank aligned to the pixel pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = VGA_640X480_CLK_DIV,
  parameter int H_ACTIVE = VGA_640X480_H.active,
  parameter int H_FP     = VGA_640X480_H.fp,
  parameter int H_SYNC   = VGA_640X480_H.sync,
  parameter int H_BP     = VGA_640X480_H.bp,
  parameter int V_ACTIVE = VGA_640X480_V.active,
  parameter int V_FP     = VGA_640X480_V.fp,
  parameter int V_SYNC   = VGA_640X480_V.sync,
  parameter int V_BP     = VGA_640X480_V.bp,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE     = DEFAULT_PIPE
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic run,
  output logic pix_en,
  output logic Hsync,
  output logic Vsync,
  output logic displayON,
  output logic [span_width(H_ACTIVE, H_FP, H_SYNC, H_BP)-1:0] Xpixel,
  output logic [span_width(V_ACTIVE, V_FP, V_SYNC, V_BP)-1:0] Ypixel,
  output logic line_start,
  output logic frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = span_width(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VW = span_width(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] X_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] X_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] Y_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] Y_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Idle value of {hs, vs, de}: syncs inactive, blanked.
  localparam logic [2:0] SYNC_IDLE = {~HS_POL, ~VS_POL, 1'b0};

  logic [DW-1:0] div;
  logic          tick;
  logic          x_wrap;
  logic          y_wrap;
  logic          hs_act;
  logic          vs_act;
  logic          de_raw;
  logic [2:0]    sync_raw;
  logic [2:0]    sync_dly;

  always_comb begin
    tick     = run && (div == DIV_LAST);
    x_wrap   = (Xpixel == X_LAST);
    y_wrap   = (Ypixel == Y_LAST);
    hs_act   = (Xpixel >= HS_FIRST) && (Xpixel <= HS_LAST);
    vs_act   = (Ypixel >= VS_FIRST) && (Ypixel <= VS_LAST);
    de_raw   = (Xpixel < X_VIS) && (Ypixel < Y_VIS);
    sync_raw = {hs_act ? HS_POL : ~HS_POL, vs_act ? VS_POL : ~VS_POL, de_raw};
  end

  // Counters move on the same edge that raises pix_en, so pix_en marks a fresh position.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      div         <= '0;
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      Xpixel      <= '0;
      Ypixel      <= '0;
      frame_count <= '0;
    end else if (!run) begin
      div         <= '0;
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      Xpixel      <= '0;
      Ypixel      <= '0;
    end else begin
      pix_en      <= tick;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      div         <= tick ? '0 : div + 1'b1;
      if (tick) begin
        if (x_wrap) begin
          Xpixel     <= '0;
          line_start <= 1'b1;
          if (y_wrap) begin
            Ypixel      <= '0;
            frame_start <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end else begin
            Ypixel <= Ypixel + 1'b1;
          end
        end else begin
          Xpixel <= Xpixel + 1'b1;
        end
      end
    end
  end

  vga_sync_delay #(
    .DEPTH (PIPE),
    .INIT  (SYNC_IDLE)
  ) u_sync_delay (
    .clk_sys (CLK),
    .rst_b   (reset_n),
    .en      (pix_en),
    .clr     (~run),
    .d       (sync_raw),
    .q       (sync_dly)
  );

  assign Hsync     = sync_dly[2];
  assign Vsync     = sync_dly[1];
  assign displayON = sync_dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small rasters at several PIPE/CLK_DIV/polarity
// settings plus the default 640x480 instance for line length and run/reset behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n;
  logic run_def;
  logic run_sm;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // default 640x480, CLK_DIV=2, PIPE=1
  logic pix_def, hs_def, vs_def, de_def, ls_def, fs_def;
  logic [9:0] x_def, y_def;
  logic [15:0] fc_def;
  vga_timing_gen u_def (
    .CLK(clk), .reset_n(reset_n), .run(run_def), .pix_en(pix_def), .Hsync(hs_def),
    .Vsync(vs_def), .displayON(de_def), .Xpixel(x_def), .Ypixel(y_def),
    .line_start(ls_def), .frame_start(fs_def), .frame_count(fc_def)
  );

  // small raster H 4/1/2/1 (total 8), V 3/1/1/1 (total 6)
  logic pix_s0, hs_s0, vs_s0, de_s0, ls_s0, fs_s0;
  logic [2:0] x_s0, y_s0;
  logic [15:0] fc_s0;
  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE(0)) u_s0 (
    .CLK(clk), .reset_n(reset_n), .run(run_sm), .pix_en(pix_s0), .Hsync(hs_s0),
    .Vsync(vs_s0), .displayON(de_s0), .Xpixel(x_s0), .Ypixel(y_s0),
    .line_start(ls_s0), .frame_start(fs_s0), .frame_count(fc_s0)
  );

  logic pix_s3, hs_s3, vs_s3, de_s3, ls_s3, fs_s3;
  logic [2:0] x_s3, y_s3;
  logic [15:0] fc_s3;
  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE(3)) u_s3 (
    .CLK(clk), .reset_n(reset_n), .run(run_sm), .pix_en(pix_s3), .Hsync(hs_s3),
    .Vsync(vs_s3), .displayON(de_s3), .Xpixel(x_s3), .Ypixel(y_s3),
    .line_start(ls_s3), .frame_start(fs_s3), .frame_count(fc_s3)
  );

  logic pix_hp, hs_hp, vs_hp, de_hp, ls_hp, fs_hp;
  logic [2:0] x_hp, y_hp;
  logic [15:0] fc_hp;
  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE(0),
                   .HS_POL(1'b1)) u_hp (
    .CLK(clk), .reset_n(reset_n), .run(run_sm), .pix_en(pix_hp), .Hsync(hs_hp),
    .Vsync(vs_hp), .displayON(de_hp), .Xpixel(x_hp), .Ypixel(y_hp),
    .line_start(ls_hp), .frame_start(fs_hp), .frame_count(fc_hp)
  );

  logic pix_d3, hs_d3, vs_d3, de_d3, ls_d3, fs_d3;
  logic [2:0] x_d3, y_d3;
  logic [15:0] fc_d3;
  vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE(0)) u_d3 (
    .CLK(clk), .reset_n(reset_n), .run(run_sm), .pix_en(pix_d3), .Hsync(hs_d3),
    .Vsync(vs_d3), .displayON(de_d3), .Xpixel(x_d3), .Ypixel(y_d3),
    .line_start(ls_d3), .frame_start(fs_d3), .frame_count(fc_d3)
  );

  bit count_en = 1'b0;
  int ls_cnt = 0;
  int fs_cnt = 0;
  always @(negedge clk) begin
    if (count_en) begin
      ls_cnt = ls_cnt + int'(ls_s0);
      fs_cnt = fs_cnt + int'(fs_s0);
    end
  end

  // k = clock edges since reset release; expectations for the small raster at that edge
  typedef struct {
    int k; int x; int y;
    bit hs; bit vs; bit de; bit ls; bit fs; int fc;
    bit hs3; bit de3;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int cyc;
    int n_def, n_s0, n_d3, n_pix, n_hs_low, n_de;
    bit ok;

    vecs[0]  = '{k: 1,  x: 1, y: 0, hs: 1, vs: 1, de: 0, ls: 0, fs: 0, fc: 0, hs3: 1, de3: 0};
    vecs[1]  = '{k: 2,  x: 2, y: 0, hs: 1, vs: 1, de: 1, ls: 0, fs: 0, fc: 0, hs3: 1, de3: 0};
    vecs[2]  = '{k: 5,  x: 5, y: 0, hs: 1, vs: 1, de: 0, ls: 0, fs: 0, fc: 0, hs3: 1, de3: 1};
    vecs[3]  = '{k: 6,  x: 6, y: 0, hs: 0, vs: 1, de: 0, ls: 0, fs: 0, fc: 0, hs3: 1, de3: 1};
    vecs[4]  = '{k: 7,  x: 7, y: 0, hs: 0, vs: 1, de: 0, ls: 0, fs: 0, fc: 0, hs3: 1, de3: 1};
    vecs[5]  = '{k: 8,  x: 0, y: 1, hs: 1, vs: 1, de: 0, ls: 1, fs: 0, fc: 0, hs3: 1, de3: 0};
    vecs[6]  = '{k: 9,  x: 1, y: 1, hs: 1, vs: 1, de: 1, ls: 0, fs: 0, fc: 0, hs3: 0, de3: 0};
    vecs[7]  = '{k: 10, x: 2, y: 1, hs: 1, vs: 1, de: 1, ls: 0, fs: 0, fc: 0, hs3: 0, de3: 0};
    vecs[8]  = '{k: 11, x: 3, y: 1, hs: 1, vs: 1, de: 1, ls: 0, fs: 0, fc: 0, hs3: 1, de3: 0};
    vecs[9]  = '{k: 12, x: 4, y: 1, hs: 1, vs: 1, de: 1, ls: 0, fs: 0, fc: 0, hs3: 1, de3: 1};
    vecs[10] = '{k: 26, x: 2, y: 3, hs: 1, vs: 1, de: 0, ls: 0, fs: 0, fc: 0, hs3: 0, de3: 0};
    vecs[11] = '{k: 33, x: 1, y: 4, hs: 1, vs: 0, de: 0, ls: 0, fs: 0, fc: 0, hs3: 0, de3: 0};
    vecs[12] = '{k: 40, x: 0, y: 5, hs: 1, vs: 0, de: 0, ls: 1, fs: 0, fc: 0, hs3: 1, de3: 0};
    vecs[13] = '{k: 41, x: 1, y: 5, hs: 1, vs: 1, de: 0, ls: 0, fs: 0, fc: 0, hs3: 0, de3: 0};
    vecs[14] = '{k: 48, x: 0, y: 0, hs: 1, vs: 1, de: 0, ls: 1, fs: 1, fc: 1, hs3: 1, de3: 0};
    vecs[15] = '{k: 49, x: 1, y: 0, hs: 1, vs: 1, de: 1, ls: 0, fs: 0, fc: 1, hs3: 0, de3: 0};
    vecs[16] = '{k: 96, x: 0, y: 0, hs: 1, vs: 1, de: 0, ls: 1, fs: 1, fc: 2, hs3: 1, de3: 0};

    reset_n = 1'b0;
    run_def = 1'b1;
    run_sm  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_hsync", hs_def, 1);
    check("rst_vsync", vs_def, 1);
    check("rst_de", de_def, 0);
    check("rst_x", x_def, 0);
    check("rst_y", y_def, 0);
    check("rst_fc", fc_def, 0);
    check("rst_pix_en", pix_def, 0);
    check("rst_hsync_pol1", hs_hp, 0);

    @(negedge clk);
    reset_n  = 1'b1;
    count_en = 1'b1;
    cyc = 0;
    foreach (vecs[i]) begin
      repeat (vecs[i].k - cyc) @(posedge clk);
      cyc = vecs[i].k;
      #1;
      check($sformatf("k%0d_x", cyc), x_s0, vecs[i].x);
      check($sformatf("k%0d_y", cyc), y_s0, vecs[i].y);
      check($sformatf("k%0d_hsync", cyc), hs_s0, vecs[i].hs);
      check($sformatf("k%0d_vsync", cyc), vs_s0, vecs[i].vs);
      check($sformatf("k%0d_de", cyc), de_s0, vecs[i].de);
      check($sformatf("k%0d_line_start", cyc), ls_s0, vecs[i].ls);
      check($sformatf("k%0d_frame_start", cyc), fs_s0, vecs[i].fs);
      check($sformatf("k%0d_frame_count", cyc), fc_s0, vecs[i].fc);
      check($sformatf("k%0d_pipe3_x", cyc), x_s3, vecs[i].x);
      check($sformatf("k%0d_pipe3_hsync", cyc), hs_s3, vecs[i].hs3);
      check($sformatf("k%0d_pipe3_de", cyc), de_s3, vecs[i].de3);
      check($sformatf("k%0d_pol1_hsync", cyc), hs_hp, !vecs[i].hs);
    end
    @(negedge clk);
    #1 count_en = 1'b0;
    check("line_starts_96", ls_cnt, 12);
    check("frame_starts_96", fs_cnt, 2);

    n_def = 0; n_s0 = 0; n_d3 = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      n_def += int'(pix_def);
      n_s0  += int'(pix_s0);
      n_d3  += int'(pix_d3);
    end
    check("pix_en_div2", n_def, 6);
    check("pix_en_div1", n_s0, 12);
    check("pix_en_div3", n_d3, 4);

    // stop and restart the small rasters mid-frame
    run_sm = 1'b0;
    @(posedge clk); #1;
    check("stop_x", x_s0, 0);
    check("stop_y", y_s0, 0);
    check("stop_de", de_s0, 0);
    check("stop_hsync", hs_s0, 1);
    check("stop_pix_en", pix_s0, 0);
    check("stop_fc_hold", fc_s0, 2);
    check("stop_pipe3_de", de_s3, 0);
    @(posedge clk); #1;
    run_sm = 1'b1;
    @(posedge clk); #1;
    check("restart_pix_en", pix_s0, 1);
    check("restart_x", x_s0, 1);
    check("restart_fs", fs_s0, 0);
    check("restart_fc", fc_s0, 2);
    check("restart_div3_e1", pix_d3, 0);
    @(posedge clk); #1;
    check("restart_div3_e2", pix_d3, 0);
    @(posedge clk); #1;
    check("restart_div3_e3", pix_d3, 1);
    check("restart_div3_x", x_d3, 1);
    check("restart_div3_fs", fs_d3, 0);

    // default 640x480 line length and sync/visible widths
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (ls_def) begin ok = 1'b1; break; end
    end
    check("def_first_line_start", ok, 1);
    n_pix = 0; n_hs_low = 0; n_de = 0; ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (pix_def) begin
        n_pix++;
        n_hs_low += int'(!hs_def);
        n_de += int'(de_def);
      end
      if (ls_def) begin ok = 1'b1; break; end
    end
    check("def_second_line_start", ok, 1);
    check("def_pix_per_line", n_pix, 800);
    check("def_hsync_width", n_hs_low, 96);
    check("def_visible_width", n_de, 640);
    check("def_y_after_two_lines", y_def, 2);

    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (x_def == 10'd123) begin ok = 1'b1; break; end
    end
    check("def_reach_x123", ok, 1);
    run_def = 1'b0;
    @(posedge clk); #1;
    check("def_stop_x", x_def, 0);
    check("def_stop_y", y_def, 0);
    check("def_stop_de", de_def, 0);
    check("def_stop_hsync", hs_def, 1);
    check("def_stop_pix_en", pix_def, 0);

    run_def = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("def_resume_x", x_def, 20);
    check("def_resume_y", y_def, 0);
    check("def_resume_de", de_def, 1);

    // reset pulse between clock edges
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_x", x_def, 0);
    check("async_rst_de", de_def, 0);
    check("async_rst_hsync", hs_def, 1);
    check("async_rst_pix_en", pix_def, 0);
    check("async_rst_fc_small", fc_s0, 0);
    check("async_rst_small_x", x_s0, 0);
    repeat (2) @(posedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
